// File: rtl/exe_div_unit_pkg.sv
// Shared types and constants for the EXE-stage divider.
package exe_div_unit_pkg;

    // Divider sequencer states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } div_state_t;

    // Cycles a nonzero-divisor operation occupies EXE: 1 IDLE + 32 ON + 1 END.
    localparam int DIV_CYCLES = 34;

    // Cycles a zero-divisor operation occupies EXE: IDLE, DIVZERO, END.
    localparam int DIV_ZERO_CYCLES = 3;

endpackage

// File: rtl/exe_div_unit_if.sv
// Request/result bundle between the EXE stage and the divider.
interface exe_div_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              flush;
    logic [DATA_W-1:0] div_quot;
    logic [DATA_W-1:0] div_rem;
    logic              div_ready;
    logic              stallreq_div;

    modport master (
        output div_start, div_signed, dividend, divisor, flush,
        input  div_quot, div_rem, div_ready, stallreq_div
    );

    modport slave (
        input  div_start, div_signed, dividend, divisor, flush,
        output div_quot, div_rem, div_ready, stallreq_div
    );
endinterface

// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
module exe_div_unit
    import exe_div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic           cpu_clk_50M,
    input  logic           cpu_rst_n,
    exe_div_unit_if.slave  bus
);

    div_state_t          r_state;
    div_state_t          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W:0]   r_work;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_quot_neg;
    logic                r_rem_neg;
    logic [DATA_W-1:0]   r_quot;
    logic [DATA_W-1:0]   r_rem;
    logic                r_ready;

    logic                w_cancel;
    logic                w_last;
    logic [DATA_W-1:0]   w_abs_dvd;
    logic [DATA_W-1:0]   w_abs_dvs;
    logic [2*DATA_W:0]   w_shift;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W:0]   w_next_work;
    logic [DATA_W-1:0]   w_quot_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic                w_unused;

    assign w_cancel = bus.flush || !bus.div_start;
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

    assign w_abs_dvd = (bus.div_signed && bus.dividend[DATA_W-1]) ? -bus.dividend : bus.dividend;
    assign w_abs_dvs = (bus.div_signed && bus.divisor[DATA_W-1])  ? -bus.divisor  : bus.divisor;

    assign w_shift     = {r_work[2*DATA_W-1:0], 1'b0};
    assign w_trial     = w_shift[2*DATA_W:DATA_W] - {1'b0, r_divisor};
    assign w_next_work = w_trial[DATA_W] ? w_shift
                                         : {w_trial, w_shift[DATA_W-1:1], 1'b1};

    assign w_quot_fix = r_quot_neg ? -w_next_work[DATA_W-1:0]        : w_next_work[DATA_W-1:0];
    assign w_rem_fix  = r_rem_neg  ? -w_next_work[2*DATA_W-1:DATA_W] : w_next_work[2*DATA_W-1:DATA_W];

    // The partial remainder stays below the divisor, so the top working bit is always zero.
    assign w_unused = &{1'b0, r_work[2*DATA_W], w_next_work[2*DATA_W]};

    // State register.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) r_state <= DIV_IDLE;
        else            r_state <= w_next_state;
    end

    // Next-state decode; flush or a dropped start abandons the operation.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (!w_cancel) w_next_state = (bus.divisor == '0) ? DIV_ZERO : DIV_ON;
            end
            DIV_ZERO: w_next_state = w_cancel ? DIV_IDLE : DIV_END;
            DIV_ON: begin
                if (w_cancel)    w_next_state = DIV_IDLE;
                else if (w_last) w_next_state = DIV_END;
            end
            DIV_END:  w_next_state = DIV_IDLE;
            default:  w_next_state = DIV_IDLE;
        endcase
    end

    // Operand latch, shift/subtract iteration and result load.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_cnt      <= '0;
            r_work     <= '0;
            r_divisor  <= '0;
            r_quot_neg <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= (w_next_state == DIV_END);
            case (r_state)
                DIV_IDLE: begin
                    r_cnt <= '0;
                    if (w_next_state == DIV_ON) begin
                        r_work     <= {{(DATA_W+1){1'b0}}, w_abs_dvd};
                        r_divisor  <= w_abs_dvs;
                        r_quot_neg <= bus.div_signed && (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
                        r_rem_neg  <= bus.div_signed && bus.dividend[DATA_W-1];
                    end
                end
                DIV_ON: begin
                    if (w_cancel) begin
                        r_cnt <= '0;
                    end else begin
                        r_work <= w_next_work;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_quot <= w_quot_fix;
                            r_rem  <= w_rem_fix;
                        end
                    end
                end
                DIV_ZERO: begin
                    r_cnt <= '0;
                    if (!w_cancel) begin
                        r_quot <= '1;
                        r_rem  <= bus.dividend;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.div_quot     = r_quot;
    assign bus.div_rem      = r_rem;
    assign bus.div_ready    = r_ready;
    assign bus.stallreq_div = cpu_rst_n && !bus.flush &&
                              ((r_state == DIV_ON) || (r_state == DIV_ZERO) ||
                               ((r_state == DIV_IDLE) && bus.div_start));

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed self-checking bench for exe_div_unit.
module tb_exe_div_unit;
    import exe_div_unit_pkg::*;

    logic cpu_clk_50M;
    logic cpu_rst_n;
    int   n_chk;
    int   n_err;
    int   cyc_cnt;
    int   t_first;
    int   t_second;

    exe_div_unit_if #(.DATA_W(32)) bus ();

    exe_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .bus         (bus)
    );

    initial begin
        cpu_clk_50M = 1'b0;
        forever #10 cpu_clk_50M = ~cpu_clk_50M;
    end

    always @(posedge cpu_clk_50M) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one division from its IDLE cycle (cycle 0) up to the ready pulse.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input int lat, input string tag, output int t_ready);
        int   cyc;
        logic got;
        logic stall_ok;
        @(negedge cpu_clk_50M);
        bus.div_signed = sg;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.flush      = 1'b0;
        bus.div_start  = 1'b1;
        cyc      = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        t_ready  = -1;
        while (!got && cyc <= lat + 5) begin
            #1;
            if (bus.div_ready === 1'b1) begin
                got     = 1'b1;
                t_ready = cyc_cnt;
            end else begin
                if (bus.stallreq_div !== 1'b1) stall_ok = 1'b0;
                @(negedge cpu_clk_50M);
                cyc++;
            end
        end
        chk({tag, "_ready_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({tag, "_latency"}, cyc, lat);
            chk({tag, "_quot"}, bus.div_quot, eq);
            chk({tag, "_rem"}, bus.div_rem, er);
            chk({tag, "_stall_end"}, {31'd0, bus.stallreq_div}, 32'd0);
        end
        chk({tag, "_stall_run"}, {31'd0, stall_ok}, 32'd1);
    endtask

    task automatic idle_cycle();
        @(negedge cpu_clk_50M);
        bus.div_start = 1'b0;
    endtask

    task automatic no_ready_for(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge cpu_clk_50M);
            #1;
            if (bus.div_ready !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int t_dummy;
        n_chk         = 0;
        n_err         = 0;
        cyc_cnt       = 0;
        cpu_rst_n     = 1'b0;
        bus.div_start = 1'b1;
        bus.div_signed= 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.flush     = 1'b0;

        #5;
        chk("rst_stall", {31'd0, bus.stallreq_div}, 32'd0);
        chk("rst_quot", bus.div_quot, 32'd0);
        chk("rst_rem", bus.div_rem, 32'd0);
        chk("rst_ready", {31'd0, bus.div_ready}, 32'd0);
        @(negedge cpu_clk_50M);
        bus.div_start = 1'b0;
        cpu_rst_n     = 1'b1;
        #1;
        chk("idle_stall", {31'd0, bus.stallreq_div}, 32'd0);

        run_div(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, DIV_CYCLES - 1, "divu_7_2", t_dummy);
        idle_cycle();
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, DIV_CYCLES - 1, "div_m7_2", t_dummy);
        idle_cycle();
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, DIV_CYCLES - 1, "divu_big_2", t_dummy);
        idle_cycle();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, DIV_CYCLES - 1, "div_7_m2", t_dummy);
        idle_cycle();
        run_div(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, DIV_ZERO_CYCLES - 1, "div_by0", t_dummy);
        idle_cycle();

        // Flush part-way through ON.
        @(negedge cpu_clk_50M);
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd1000;
        bus.divisor    = 32'd3;
        bus.div_start  = 1'b1;
        repeat (11) @(negedge cpu_clk_50M);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, bus.stallreq_div}, 32'd0);
        chk("flush_ready", {31'd0, bus.div_ready}, 32'd0);
        @(negedge cpu_clk_50M);
        bus.flush     = 1'b0;
        bus.div_start = 1'b0;
        #1;
        chk("flush_after_ready", {31'd0, bus.div_ready}, 32'd0);
        chk("flush_hold_quot", bus.div_quot, 32'hFFFF_FFFF);
        chk("flush_hold_rem", bus.div_rem, 32'h1234_5678);
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, DIV_CYCLES - 1, "divu_100_7", t_dummy);
        idle_cycle();

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, DIV_CYCLES - 1, "div_ovf", t_dummy);
        idle_cycle();

        // Back-to-back: second DIVU enters EXE the cycle after END.
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, DIV_CYCLES - 1, "b2b_9_3", t_first);
        run_div(1'b0, 32'd10, 32'd4, 32'd2, 32'd2, DIV_CYCLES - 1, "b2b_10_4", t_second);
        chk("b2b_spacing", t_second - t_first, DIV_CYCLES);
        idle_cycle();

        // div_start dropping mid-operation cancels without a result.
        @(negedge cpu_clk_50M);
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd50;
        bus.divisor    = 32'd5;
        bus.div_start  = 1'b1;
        repeat (5) @(negedge cpu_clk_50M);
        bus.div_start = 1'b0;
        no_ready_for(40, "cancel_no_ready");
        chk("cancel_hold_quot", bus.div_quot, 32'd2);

        // Asynchronous reset mid-ON.
        @(negedge cpu_clk_50M);
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        bus.div_start = 1'b1;
        repeat (6) @(negedge cpu_clk_50M);
        #3;
        cpu_rst_n = 1'b0;
        #1;
        chk("arst_quot", bus.div_quot, 32'd0);
        chk("arst_rem", bus.div_rem, 32'd0);
        chk("arst_ready", {31'd0, bus.div_ready}, 32'd0);
        chk("arst_stall", {31'd0, bus.stallreq_div}, 32'd0);
        @(negedge cpu_clk_50M);
        bus.div_start = 1'b0;
        cpu_rst_n     = 1'b1;
        no_ready_for(40, "arst_no_ready");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
